// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   - arb_state_e : arbiter FSM encoding (IDLE, WAIT)
//   - clk_per_bit : clock cycles per UART bit (integer divide)
//   - frame_cycles: cycles reserved per byte (10-bit frame plus idle gap bits)
//   - timer_width : width of a down-counter that must hold frame_cycles
package uart_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_e;

  localparam int SRC_W = 3;

  function automatic int clk_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic int frame_cycles(input int clk_freq, input int baud,
                                      input int gap_bits);
    return clk_per_bit(clk_freq, baud) * (10 + gap_bits);
  endfunction

  function automatic int timer_width(input int frame_cyc);
    return $clog2(frame_cyc + 1);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//   req    : request vector
//   ptr    : index that has highest priority this round
//   any    : at least one request set
//   winner : first set request at or after ptr, wrapping at N-1 -> 0
// The request vector is rotated so ptr lands at bit 0, the lowest set bit
// is priority-encoded, and the result is rotated back by adding ptr mod N.
module rr_picker #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          any,
  output logic [PW-1:0] winner
);

  logic [N-1:0]  rot;
  logic [PW-1:0] idx;

  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = req[(i + int'(ptr)) % N];
    end
    idx = '0;
    // descending scan so the lowest set bit is the last assignment
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) idx = PW'(i);
    end
    any    = |req;
    winner = PW'((int'(idx) + int'(ptr)) % N);
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter in front of a single UART byte transmitter.
// Grants one requester per frame, pulses dout_vld for one cycle and then
// holds off for a full frame time, since the transmitter gives no busy.
//   clk, rst   : clock, synchronous active-high reset
//   req        : per-requester request level (held with data until grant)
//   req_data   : byte of requester i at [8i+7:8i]
//   grant      : one-hot, one-cycle accept pulse
//   dout_vld   : one-cycle launch pulse to the transmitter
//   dout_data  : launched byte, held for the whole frame
//   busy       : high for exactly FRAME_CYCLES cycles from launch
//   last_src   : index of the most recently granted requester
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600,
  parameter int NUM_REQ  = 4,
  parameter int GAP_BITS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   dout_vld,
  output logic [7:0]             dout_data,
  output logic                   busy,
  output logic [SRC_W-1:0]       last_src
);

  localparam int FRAME_CYCLES = frame_cycles(CLK_FREQ, BAUD, GAP_BITS);
  localparam int TMR_W        = timer_width(FRAME_CYCLES);
  localparam int PW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e                   state;
  logic [TMR_W-1:0]             timer;
  logic [PW-1:0]                ptr;
  logic                         any;
  logic [PW-1:0]                winner;
  logic [NUM_REQ-1:0][7:0]      req_bytes;
  logic [NUM_REQ-1:0]           win_oh;

  assign req_bytes = req_data;

  rr_picker #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .any    (any),
    .winner (winner)
  );

  always_comb begin
    win_oh         = '0;
    win_oh[winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      ptr       <= '0;
      grant     <= '0;
      dout_vld  <= 1'b0;
      dout_data <= 8'h00;
      busy      <= 1'b0;
      last_src  <= '0;
    end else begin
      grant    <= '0;
      dout_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            grant     <= win_oh;
            dout_vld  <= 1'b1;
            dout_data <= req_bytes[winner];
            busy      <= 1'b1;
            last_src  <= SRC_W'(winner);
            timer     <= TMR_W'(FRAME_CYCLES - 1);
            ptr       <= (winner == PW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          // timer counts FRAME_CYCLES-1..0, so busy covers FRAME_CYCLES cycles
          if (timer == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
